// File: rtl/usb_wishbone_bi.sv
// Wishbone-style bus bridge that fans one bus request out to the USB host/slave
// sub-blocks as a single strobe, then returns registered read data with one ack.
module usb_wishbone_bi #(
    parameter int FIFO_RD_LAT = 2
) (
    input  logic       busClk,
    input  logic       rst_n,
    input  logic [7:0] address_i,
    input  logic [7:0] dataIn_i,
    output logic [7:0] dataOut_o,
    input  logic       we_i,
    input  logic       strobe_i,
    output logic       ack_o,
    output logic [3:0] address_o,
    output logic [7:0] dataOut_sub,
    output logic       writeEn,
    output logic       strobe_o,
    output logic       hostCtrlSel,
    output logic       hostSlaveMuxSel,
    output logic       hostRxFifoSel,
    output logic       hostTxFifoSel,
    output logic       slaveCtrlSel,
    output logic       slaveRxFifoSel,
    output logic       slaveTxFifoSel,
    input  logic [7:0] hostCtrlData,
    input  logic [7:0] hostSlaveMuxData,
    input  logic [7:0] hostRxFifoData,
    input  logic [7:0] slaveCtrlData,
    input  logic [7:0] slaveRxFifoData
);

    typedef enum logic [2:0] {
        IDLE,
        STROBE,
        WAIT,
        ACK,
        HOLD
    } state_t;

    state_t     state;
    state_t     nextState;
    logic [6:0] sel;
    logic [6:0] selNext;
    logic [1:0] waitCnt;
    logic [7:0] readMux;
    logic       rxRead;

    assign {hostCtrlSel, hostSlaveMuxSel, hostRxFifoSel, hostTxFifoSel,
            slaveCtrlSel, slaveRxFifoSel, slaveTxFifoSel} = sel;

    assign rxRead = !writeEn && (sel[4] || sel[1]);

    always_comb begin
        selNext = 7'b0;
        case (address_i[7:4])
            4'h0: selNext = 7'b1000000;
            4'h1: selNext = 7'b0100000;
            4'h2: selNext = 7'b0010000;
            4'h3: selNext = 7'b0001000;
            4'h4: selNext = 7'b0000100;
            4'h5: selNext = 7'b0000010;
            4'h6: selNext = 7'b0000001;
            default: selNext = 7'b0;
        endcase
    end

    // Tx FIFOs and unmapped regions read back as zero.
    always_comb begin
        readMux = 8'h00;
        unique case (1'b1)
            sel[6]: readMux = hostCtrlData;
            sel[5]: readMux = hostSlaveMuxData;
            sel[4]: readMux = hostRxFifoData;
            sel[2]: readMux = slaveCtrlData;
            sel[1]: readMux = slaveRxFifoData;
            default: readMux = 8'h00;
        endcase
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:   if (strobe_i) nextState = STROBE;
            STROBE: nextState = (rxRead && FIFO_RD_LAT > 1) ? WAIT : ACK;
            WAIT:   if (waitCnt == 2'(FIFO_RD_LAT - 2)) nextState = ACK;
            ACK:    nextState = HOLD;
            HOLD:   if (!strobe_i) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge busClk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_ff @(posedge busClk or negedge rst_n) begin
        if (!rst_n) begin
            sel         <= 7'b0;
            writeEn     <= 1'b0;
            strobe_o    <= 1'b0;
            ack_o       <= 1'b0;
            address_o   <= 4'h0;
            dataOut_sub <= 8'h00;
            dataOut_o   <= 8'h00;
            waitCnt     <= 2'd0;
        end else begin
            strobe_o <= 1'b0;
            ack_o    <= 1'b0;
            if (state == IDLE && strobe_i) begin
                address_o   <= address_i[3:0];
                dataOut_sub <= dataIn_i;
                writeEn     <= we_i;
                sel         <= selNext;
                strobe_o    <= 1'b1;
                waitCnt     <= 2'd0;
            end
            if (state == WAIT) waitCnt <= waitCnt + 2'd1;
            // A request withdrawn before ACK still completes, just silently.
            if (nextState == ACK && state != ACK) begin
                ack_o <= strobe_i;
                if (!writeEn) dataOut_o <= readMux;
            end
            if (nextState == HOLD) begin
                sel     <= 7'b0;
                writeEn <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_usb_wishbone_bi.sv
// Directed bench for usb_wishbone_bi: a scoreboard queue holds the expected
// dataOut_o per request; it is popped and compared when ack_o appears.
module tb_usb_wishbone_bi;

    logic       busClk = 1'b0;
    logic       rst_n;
    logic [7:0] address_i;
    logic [7:0] dataIn_i;
    logic [7:0] dataOut_o;
    logic       we_i;
    logic       strobe_i;
    logic       ack_o;
    logic [3:0] address_o;
    logic [7:0] dataOut_sub;
    logic       writeEn;
    logic       strobe_o;
    logic       hostCtrlSel, hostSlaveMuxSel, hostRxFifoSel, hostTxFifoSel;
    logic       slaveCtrlSel, slaveRxFifoSel, slaveTxFifoSel;
    logic [7:0] hostCtrlData, hostSlaveMuxData, hostRxFifoData;
    logic [7:0] slaveCtrlData, slaveRxFifoData;

    int         tests = 0;
    int         failed = 0;
    logic [7:0] sb[$];
    logic [7:0] expOut;

    usb_wishbone_bi #(.FIFO_RD_LAT(2)) dut (
        .busClk(busClk), .rst_n(rst_n),
        .address_i(address_i), .dataIn_i(dataIn_i), .dataOut_o(dataOut_o),
        .we_i(we_i), .strobe_i(strobe_i), .ack_o(ack_o),
        .address_o(address_o), .dataOut_sub(dataOut_sub),
        .writeEn(writeEn), .strobe_o(strobe_o),
        .hostCtrlSel(hostCtrlSel), .hostSlaveMuxSel(hostSlaveMuxSel),
        .hostRxFifoSel(hostRxFifoSel), .hostTxFifoSel(hostTxFifoSel),
        .slaveCtrlSel(slaveCtrlSel), .slaveRxFifoSel(slaveRxFifoSel),
        .slaveTxFifoSel(slaveTxFifoSel),
        .hostCtrlData(hostCtrlData), .hostSlaveMuxData(hostSlaveMuxData),
        .hostRxFifoData(hostRxFifoData), .slaveCtrlData(slaveCtrlData),
        .slaveRxFifoData(slaveRxFifoData)
    );

    always #5 busClk = ~busClk;

    function automatic logic [6:0] selVec();
        return {hostCtrlSel, hostSlaveMuxSel, hostRxFifoSel, hostTxFifoSel,
                slaveCtrlSel, slaveRxFifoSel, slaveTxFifoSel};
    endfunction

    function automatic logic [29:0] allOut();
        return {ack_o, strobe_o, writeEn, selVec(), dataOut_o, address_o, dataOut_sub};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // FIFO data changes every cycle so the capture cycle is observable.
    function automatic logic [7:0] readModel(input logic [7:0] addr, input int lat);
        case (addr[7:4])
            4'h0: return 8'hA1;
            4'h1: return 8'h22;
            4'h2: return 8'(8'h30 + lat - 1);
            4'h4: return 8'hC4;
            4'h5: return 8'(8'h30 + lat - 1);
            default: return 8'h00;
        endcase
    endfunction

    task automatic txn(input string tag, input logic [7:0] addr, input logic [7:0] din,
                       input logic we, input int holdLen, input int expLat,
                       input logic [6:0] expSel);
        int sN = 0;
        int aN = 0;
        int aCyc = -1;
        logic [7:0] popped;
        if (!we) expOut = readModel(addr, expLat);
        if (expLat > 0) sb.push_back(expOut);
        @(negedge busClk);
        address_i = addr;
        dataIn_i  = din;
        we_i      = we;
        strobe_i  = 1'b1;
        for (int c = 1; c <= holdLen + 4; c++) begin
            @(posedge busClk);
            #1;
            hostRxFifoData  = 8'(8'h30 + c);
            slaveRxFifoData = 8'(8'h30 + c);
            if (strobe_o) sN++;
            if (c == 1)
                check({tag, " cyc1"}, {selVec(), writeEn, address_o, dataOut_sub},
                      {expSel, we, addr[3:0], din});
            if (expLat > 0 && c == expLat + 1)
                check({tag, " selclr"}, {selVec(), writeEn}, 8'h00);
            if (ack_o) begin
                aN++;
                aCyc = c;
                if (sb.size() > 0) begin
                    popped = sb.pop_front();
                    check({tag, " data"}, dataOut_o, popped);
                end else begin
                    check({tag, " sbempty"}, 1, 0);
                end
            end
            if (c == holdLen) strobe_i = 1'b0;
        end
        check({tag, " strobes"}, sN, 1);
        check({tag, " acks"}, aN, (expLat > 0) ? 1 : 0);
        if (expLat > 0) check({tag, " lat"}, aCyc, expLat);
    endtask

    initial begin
        rst_n = 1'b0;
        address_i = 8'h00;
        dataIn_i = 8'h00;
        we_i = 1'b0;
        strobe_i = 1'b0;
        hostCtrlData = 8'hA1;
        hostSlaveMuxData = 8'h22;
        hostRxFifoData = 8'h30;
        slaveCtrlData = 8'hC4;
        slaveRxFifoData = 8'h30;
        expOut = 8'h00;
        #3;
        check("reset", allOut(), 30'h0);
        @(negedge busClk);
        rst_n = 1'b1;
        @(negedge busClk);

        txn("wr10",   8'h10, 8'h03, 1'b1, 2,  2, 7'b0100000);
        txn("rd11",   8'h11, 8'h00, 1'b0, 2,  2, 7'b0100000);
        txn("rd20",   8'h20, 8'h00, 1'b0, 3,  3, 7'b0010000);
        txn("rd50h",  8'h50, 8'h00, 1'b0, 10, 3, 7'b0000010);
        txn("rdF0",   8'hF0, 8'h00, 1'b0, 2,  2, 7'b0000000);
        txn("rd05",   8'h05, 8'h00, 1'b0, 2,  2, 7'b1000000);
        txn("rd33tx", 8'h33, 8'h00, 1'b0, 2,  2, 7'b0001000);
        txn("wr70",   8'h70, 8'h5A, 1'b1, 2,  2, 7'b0000000);
        txn("abort",  8'h60, 8'h77, 1'b1, 1,  0, 7'b0000001);
        txn("rd42",   8'h42, 8'h00, 1'b0, 2,  2, 7'b0000100);

        // Reset while waiting on the Rx FIFO.
        @(negedge busClk);
        address_i = 8'h20;
        we_i = 1'b0;
        strobe_i = 1'b1;
        @(posedge busClk);
        #1;
        @(posedge busClk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstwait", allOut(), 30'h0);
        strobe_i = 1'b0;
        @(negedge busClk);
        @(negedge busClk);
        rst_n = 1'b1;
        begin
            int acks = 0;
            for (int i = 0; i < 4; i++) begin
                @(posedge busClk);
                #1;
                if (ack_o) acks++;
            end
            check("rstnoack", acks, 0);
        end
        expOut = 8'h00;
        txn("wr40",   8'h40, 8'h9C, 1'b1, 2,  2, 7'b0000100);

        check("sbdrain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/usb_wishbone_bi.md
USB_WISHBONE_BI -- requirements
Module: usb_wishbone_bi

Interface
REQ-001 Parameter FIFO_RD_LAT, default 2: cycles from strobe_o to valid FIFO read data, legal values 1..3.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Ports (name, direction, width, meaning), clock and reset first:
- busClk  in  1: sole clock, all state on rising edge.
- rst_n  in  1: asynchronous active-low reset.
- address_i  in  8: bus address; [7:4] selects region, [3:0] is the register offset.
- dataIn_i  in  8: write data.
- dataOut_o  out  8: registered read data.
- we_i  in  1: write request.
- strobe_i  in  1: transfer request.
- ack_o  out  1: transfer done, one-cycle pulse.
- address_o  out  4: registered offset to sub-blocks.
- dataOut_sub  out  8: registered write data to sub-blocks.
- writeEn  out  1: registered write flag.
- strobe_o  out  1: one-cycle sub-block strobe.
- hostCtrlSel, hostSlaveMuxSel, hostRxFifoSel, hostTxFifoSel, slaveCtrlSel, slaveRxFifoSel, slaveTxFifoSel  out  1 each: registered region selects.
- hostCtrlData, hostSlaveMuxData, hostRxFifoData, slaveCtrlData, slaveRxFifoData  in  8 each: sub-block read data.

Function
REQ-004 Region map by address_i[7:4]:
- 0x0 hostCtrl; 0x1 hostSlaveMux; 0x2 hostRxFifo; 0x3 hostTxFifo.
- 0x4 slaveCtrl; 0x5 slaveRxFifo; 0x6 slaveTxFifo.
- 0x7-0xF unmapped.
REQ-005 The FSM SHALL have five states: IDLE, STROBE, WAIT, ACK, HOLD.
REQ-006 In IDLE with strobe_i=1, the block SHALL register address_i[3:0], dataIn_i, we_i and the one-hot region selects, then go to STROBE.
REQ-007 In STROBE, strobe_o SHALL be 1 for exactly one cycle, with selects and writeEn stable.
REQ-008 A read of an Rx FIFO region SHALL leave STROBE for WAIT and stay there FIFO_RD_LAT-1 cycles; every other access SHALL go from STROBE to ACK.
REQ-009 On entry to ACK, dataOut_o SHALL load the selected sub-block data for reads; it SHALL load 0x00 for Tx FIFO or unmapped reads; it SHALL hold its value for writes.
REQ-010 In ACK, ack_o SHALL be 1 for one cycle if strobe_i=1; the next state SHALL be HOLD.
REQ-011 In HOLD, the block SHALL wait for strobe_i=0 and then return to IDLE, so one bus request yields exactly one strobe_o.
REQ-012 Latency, counted from the strobe_i sampling edge (cycle 0) to ack_o: 2 cycles for writes and non-FIFO reads; 1+FIFO_RD_LAT cycles for Rx FIFO reads.
REQ-013 Writes to unmapped regions SHALL set no select and SHALL still be acked; strobe_o SHALL still pulse.
REQ-014 If strobe_i falls after STROBE:
- the sub-block access SHALL complete;
- ack_o SHALL be suppressed;
- the FSM SHALL still pass through ACK and go to IDLE.
REQ-015 Selects and writeEn SHALL clear on entry to HOLD or IDLE.
REQ-016 At most one select SHALL be high in any cycle.

Reset
REQ-017 While rst_n=0, asynchronously:
- FSM goes to IDLE;
- ack_o, strobe_o, writeEn and all selects go to 0;
- dataOut_o, dataOut_sub and address_o go to 0x00.
REQ-018 Reset mid-transfer SHALL abort the transfer with no ack_o; the first edge after deassertion SHALL sample in IDLE.
REQ-019 No output SHALL glitch high during or upon reset release.

Verification
REQ-020 Write 0x03 to 0x10 -> cycle 1: strobe_o=1, hostSlaveMuxSel=1, writeEn=1, address_o=0x0, dataOut_sub=0x03; cycle 2: ack_o=1.
REQ-021 Read 0x11 with hostSlaveMuxData=0x22 -> ack_o at cycle 2 with dataOut_o=0x22.
REQ-022 Read 0x20 with FIFO_RD_LAT=2 -> one strobe_o at cycle 1, ack_o at cycle 3; dataOut_o equals hostRxFifoData sampled at cycle 2.
REQ-023 Hold strobe_i high for 10 cycles on a read of 0x50 -> exactly one strobe_o and one ack_o; FSM stays in HOLD until strobe_i falls.
REQ-024 Access 0xF0 -> all selects 0, read returns 0x00, ack_o at cycle 2.
REQ-025 Assert rst_n=0 during WAIT -> no ack_o; all outputs 0 immediately; a new write to 0x40 completes normally after release.
